// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg
// Shared definitions for the Game-of-Life cell array.
//   CNT_W      : width of a per-cell live-neighbour count (0..8)
//   GEN_W      : width of the generation counter
//   BIRTH_CNT  : neighbour count that brings a dead cell to life
//   SURVIVE_LO/HI : neighbour counts that keep a live cell alive
//   op_e       : the single action applied to the grid on a clock edge
//   life_rule  : next state of one cell from its state and neighbour count
// ---------------------------------------------------------------------------
package life_pkg;

    localparam int CNT_W = 4;
    localparam int GEN_W = 16;

    localparam logic [CNT_W-1:0] BIRTH_CNT  = CNT_W'(3);
    localparam logic [CNT_W-1:0] SURVIVE_LO = CNT_W'(2);
    localparam logic [CNT_W-1:0] SURVIVE_HI = CNT_W'(3);

    typedef enum logic [1:0] {
        OP_IDLE   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_SCAN   = 2'd2,
        OP_EVOLVE = 2'd3
    } op_e;

    function automatic logic life_rule(input logic alive, input logic [CNT_W-1:0] cnt);
        if (alive) begin
            return (cnt == SURVIVE_LO) || (cnt == SURVIVE_HI);
        end
        return (cnt == BIRTH_CNT);
    endfunction

endpackage

// File: rtl/life_cell.sv
// ---------------------------------------------------------------------------
// life_cell
// One grid cell: state register plus write / scan / evolve next-state mux.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (cell goes dead)
//   op_i         : action for this edge, already priority-resolved by the top
//   wr_sel_i     : this cell is addressed by the current direct write
//   wr_val_i     : direct write data
//   scan_in_i    : value shifted into this cell on a scan edge
//   count_i      : live-neighbour count (0..8)
//   alive_o      : registered cell state
//   next_o       : state this cell would take on an evolve edge
// ---------------------------------------------------------------------------
module life_cell
    import life_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  op_e              op_i,
    input  logic             wr_sel_i,
    input  logic             wr_val_i,
    input  logic             scan_in_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             alive_o,
    output logic             next_o
);

    logic state_q;
    logic state_d;

    assign next_o  = life_rule(state_q, count_i);
    assign alive_o = state_q;

    always_comb begin
        state_d = state_q;
        case (op_i)
            // Unaddressed cells hold during a write edge.
            OP_WRITE:  if (wr_sel_i) state_d = wr_val_i;
            OP_SCAN:   state_d = scan_in_i;
            OP_EVOLVE: state_d = next_o;
            default:   state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= 1'b0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/life_array_grid.sv
// ---------------------------------------------------------------------------
// life_array_grid
// ROWS x COLS Game-of-Life array with direct cell write, a recirculating
// scan chain, free-running or single-step evolution, and status flags.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   run, step            : evolve every edge / evolve on this edge
//   write_enb, row, col, val : direct write of one cell
//   scan, scan_write_val, scan_write_enb : scan shift, serial in, load-vs-recirculate
//   scan_read_val        : chain tail (combinational)
//   n, s, e, w, nw, ne, se, sw : off-grid neighbours used when WRAP = 0
//   alive                : cell states, bit index col*ROWS+row
//   generation           : evolve edges since reset (wraps)
//   stable               : last evolve changed no cell
//   empty                : no cell alive (combinational)
// ---------------------------------------------------------------------------
module life_array_grid
    import life_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int WRAP = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     run,
    input  logic                     step,
    input  logic                     write_enb,
    input  logic [$clog2(ROWS)-1:0]  row,
    input  logic [$clog2(COLS)-1:0]  col,
    input  logic                     val,
    input  logic                     scan,
    input  logic                     scan_write_val,
    input  logic                     scan_write_enb,
    output logic                     scan_read_val,
    input  logic [COLS-1:0]          n,
    input  logic [COLS-1:0]          s,
    input  logic [ROWS-1:0]          e,
    input  logic [ROWS-1:0]          w,
    input  logic                     nw,
    input  logic                     ne,
    input  logic                     se,
    input  logic                     sw,
    output logic [ROWS*COLS-1:0]     alive,
    output logic [GEN_W-1:0]         generation,
    output logic                     stable,
    output logic                     empty
);

    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    op_e                     op;
    logic [N-1:0]            next_vec;
    logic [ROWS+1:0][COLS+1:0] pad;
    logic                    scan_head;
    logic [GEN_W-1:0]        gen_q, gen_d;
    logic                    stable_q, stable_d;
    logic                    unused_bnd;

    // Boundary inputs are not referenced by the wrapped configuration.
    assign unused_bnd = ^{n, s, e, w, nw, ne, se, sw};

    always_comb begin
        op = OP_IDLE;
        if (write_enb)        op = OP_WRITE;
        else if (scan)        op = OP_SCAN;
        else if (run || step) op = OP_EVOLVE;
    end

    // Grid padded by one ring: pad[r+1][c+1] is cell (r,c); the ring holds
    // either the boundary inputs or the wrapped opposite edge.
    always_comb begin
        pad = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                pad[r+1][c+1] = alive[c*ROWS + r];
            end
        end
        if (WRAP != 0) begin
            for (int c = 0; c < COLS; c++) begin
                pad[0][c+1]      = alive[c*ROWS + ROWS - 1];
                pad[ROWS+1][c+1] = alive[c*ROWS];
            end
            for (int r = 0; r < ROWS; r++) begin
                pad[r+1][0]      = alive[(COLS-1)*ROWS + r];
                pad[r+1][COLS+1] = alive[r];
            end
            pad[0][0]           = alive[N-1];
            pad[0][COLS+1]      = alive[ROWS-1];
            pad[ROWS+1][0]      = alive[(COLS-1)*ROWS];
            pad[ROWS+1][COLS+1] = alive[0];
        end else begin
            for (int c = 0; c < COLS; c++) begin
                pad[0][c+1]      = n[c];
                pad[ROWS+1][c+1] = s[c];
            end
            for (int r = 0; r < ROWS; r++) begin
                pad[r+1][0]      = w[r];
                pad[r+1][COLS+1] = e[r];
            end
            pad[0][0]           = nw;
            pad[0][COLS+1]      = ne;
            pad[ROWS+1][0]      = sw;
            pad[ROWS+1][COLS+1] = se;
        end
    end

    // Chain head either takes serial data or recirculates the tail.
    assign scan_head     = scan_write_enb ? scan_write_val : alive[N-1];
    assign scan_read_val = alive[N-1];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int IDX = c*ROWS + r;
            logic [CNT_W-1:0] cnt;
            logic             scan_in;
            logic             wr_sel;

            always_comb begin
                cnt = '0;
                for (int dr = 0; dr < 3; dr++) begin
                    for (int dc = 0; dc < 3; dc++) begin
                        if (!(dr == 1 && dc == 1)) begin
                            cnt = cnt + CNT_W'(pad[r+dr][c+dc]);
                        end
                    end
                end
            end

            if (IDX == 0) begin : g_head
                assign scan_in = scan_head;
            end else begin : g_link
                assign scan_in = alive[IDX-1];
            end

            // Out-of-range addresses match no cell, so the grid holds.
            assign wr_sel = (row == RW'(r)) && (col == CW'(c));

            life_cell u_cell (
                .clk       (clk),
                .reset_n   (reset_n),
                .op_i      (op),
                .wr_sel_i  (wr_sel),
                .wr_val_i  (val),
                .scan_in_i (scan_in),
                .count_i   (cnt),
                .alive_o   (alive[IDX]),
                .next_o    (next_vec[IDX])
            );
        end
    end

    always_comb begin
        gen_d    = gen_q;
        stable_d = stable_q;
        case (op)
            OP_WRITE, OP_SCAN: stable_d = 1'b0;
            OP_EVOLVE: begin
                gen_d    = gen_q + GEN_W'(1);
                stable_d = (next_vec == alive);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            gen_q    <= gen_d;
            stable_q <= stable_d;
        end
    end

    assign generation = gen_q;
    assign stable     = stable_q;
    assign empty      = ~|alive;

endmodule

// File: tb/tb_life_array_grid.sv
// ---------------------------------------------------------------------------
// tb_life_array_grid
// Directed bench for life_array_grid: a WRAP=0 instance (dut) and a WRAP=1
// instance (dut_w) driven from the same inputs.
// ---------------------------------------------------------------------------
module tb_life_array_grid;

    logic        clk;
    logic        reset_n, run, step, write_enb, val;
    logic        scan, scan_write_val, scan_write_enb;
    logic [1:0]  row, col;
    logic [3:0]  n, s, e, w;
    logic        nw, ne, se, sw;

    logic        scan_read_val, scan_read_val_w;
    logic [15:0] alive, alive_w;
    logic [15:0] generation, generation_w;
    logic        stable, stable_w, empty, empty_w;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] pat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    life_array_grid #(.ROWS(4), .COLS(4), .WRAP(0)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step),
        .write_enb(write_enb), .row(row), .col(col), .val(val),
        .scan(scan), .scan_write_val(scan_write_val), .scan_write_enb(scan_write_enb),
        .scan_read_val(scan_read_val),
        .n(n), .s(s), .e(e), .w(w), .nw(nw), .ne(ne), .se(se), .sw(sw),
        .alive(alive), .generation(generation), .stable(stable), .empty(empty)
    );

    life_array_grid #(.ROWS(4), .COLS(4), .WRAP(1)) dut_w (
        .clk(clk), .reset_n(reset_n), .run(run), .step(step),
        .write_enb(write_enb), .row(row), .col(col), .val(val),
        .scan(scan), .scan_write_val(scan_write_val), .scan_write_enb(scan_write_enb),
        .scan_read_val(scan_read_val_w),
        .n(n), .s(s), .e(e), .w(w), .nw(nw), .ne(ne), .se(se), .sw(sw),
        .alive(alive_w), .generation(generation_w), .stable(stable_w), .empty(empty_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_grid(input logic [15:0] p);
        for (int i = 0; i < 16; i++) begin
            write_enb = 1'b1;
            row       = 2'(i % 4);
            col       = 2'(i / 4);
            val       = p[i];
            tick();
        end
        write_enb = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic clear_bnd();
        n = 4'h0; s = 4'h0; e = 4'h0; w = 4'h0;
        nw = 1'b0; ne = 1'b0; se = 1'b0; sw = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b0; step = 1'b0; write_enb = 1'b0; val = 1'b0;
        scan = 1'b0; scan_write_val = 1'b0; scan_write_enb = 1'b0;
        row = 2'd0; col = 2'd0;
        clear_bnd();

        // Reset state
        #1;
        check("rst_alive", 32'(alive), 32'h0);
        check("rst_gen", 32'(generation), 32'h0);
        check("rst_stable", 32'(stable), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_scan_read", 32'(scan_read_val), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Blinker, single steps
        load_grid(16'h0222);
        check("blink_load", 32'(alive), 32'h0222);
        check("blink_not_empty", 32'(empty), 32'h0);
        step = 1'b1; tick(); step = 1'b0;
        check("blink_step1", 32'(alive), 32'h0070);
        check("blink_gen1", 32'(generation), 32'h1);
        tick();
        check("idle_hold", 32'(alive), 32'h0070);
        step = 1'b1; tick(); step = 1'b0;
        check("blink_step2", 32'(alive), 32'h0222);
        check("blink_gen2", 32'(generation), 32'h2);
        check("blink_stable", 32'(stable), 32'h0);

        // Block still life, free run
        do_reset();
        load_grid(16'h0660);
        run = 1'b1;
        repeat (5) tick();
        run = 1'b0;
        check("block_alive", 32'(alive), 32'h0660);
        check("block_stable", 32'(stable), 32'h1);
        check("block_gen", 32'(generation), 32'h5);
        write_enb = 1'b1; row = 2'd0; col = 2'd0; val = 1'b0;
        tick();
        write_enb = 1'b0;
        check("write_clears_stable", 32'(stable), 32'h0);
        check("write_keeps_alive", 32'(alive), 32'h0660);

        // West boundary births cell (1,0)
        do_reset();
        w = 4'b0111;
        step = 1'b1; tick(); step = 1'b0;
        check("west_bnd", 32'(alive), 32'h0002);
        check("west_gen", 32'(generation), 32'h1);
        clear_bnd();

        // North boundary births cell (0,1)
        do_reset();
        n = 4'b0111;
        step = 1'b1; tick(); step = 1'b0;
        check("north_bnd", 32'(alive), 32'h0010);
        clear_bnd();

        // NW corner contributes to cell (0,0)
        do_reset();
        n = 4'b0001; w = 4'b0001; nw = 1'b1;
        step = 1'b1; tick(); step = 1'b0;
        check("nw_corner", 32'(alive), 32'h0001);
        clear_bnd();

        // SE corner contributes to cell (3,3)
        do_reset();
        s = 4'b1000; e = 4'b1000; se = 1'b1;
        step = 1'b1; tick(); step = 1'b0;
        check("se_corner", 32'(alive), 32'h8000);
        clear_bnd();

        // Toroidal wrap; boundary inputs driven high must be ignored
        do_reset();
        load_grid(16'h1009);
        n = 4'hF; s = 4'hF; e = 4'hF; w = 4'hF;
        nw = 1'b1; ne = 1'b1; se = 1'b1; sw = 1'b1;
        step = 1'b1; tick(); step = 1'b0;
        check("wrap_step1", 32'(alive_w), 32'h9009);
        check("wrap_gen1", 32'(generation_w), 32'h1);
        check("wrap_unstable", 32'(stable_w), 32'h0);
        step = 1'b1; tick(); tick(); step = 1'b0;
        check("wrap_held_step", 32'(alive_w), 32'h9009);
        check("wrap_stable", 32'(stable_w), 32'h1);
        check("wrap_gen3", 32'(generation_w), 32'h3);
        clear_bnd();

        // Scan recirculation
        do_reset();
        pat = 16'h6996;
        load_grid(pat);
        scan = 1'b1; scan_write_enb = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("scan_stream", 32'(scan_read_val), 32'(pat[15-k]));
            tick();
        end
        check("scan_restore", 32'(alive), 32'h6996);
        check("scan_stable", 32'(stable), 32'h0);
        scan_write_enb = 1'b1; scan_write_val = 1'b1;
        tick();
        check("scan_load", 32'(alive), 32'hD32D);
        scan_write_enb = 1'b0; scan_write_val = 1'b0;

        // Priority: write over scan over evolve
        run = 1'b1;
        write_enb = 1'b1; row = 2'd0; col = 2'd0; val = 1'b0;
        tick();
        write_enb = 1'b0;
        check("prio_write", 32'(alive), 32'hD32C);
        tick();
        check("prio_scan", 32'(alive), 32'hA659);
        check("prio_gen", 32'(generation), 32'h0);
        scan = 1'b0; run = 1'b0;

        // Reset while running
        do_reset();
        load_grid(16'h0222);
        run = 1'b1;
        tick(); tick();
        check("run_blink", 32'(alive), 32'h0222);
        check("run_gen", 32'(generation), 32'h2);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_alive", 32'(alive), 32'h0);
        check("async_rst_gen", 32'(generation), 32'h0);
        check("async_rst_empty", 32'(empty), 32'h1);
        run = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        write_enb = 1'b1; row = 2'd0; col = 2'd0; val = 1'b1;
        tick();
        write_enb = 1'b0;
        check("single_cell", 32'(alive), 32'h0001);
        run = 1'b1; tick(); run = 1'b0;
        check("single_dies", 32'(alive), 32'h0);
        check("single_empty", 32'(empty), 32'h1);
        check("single_gen", 32'(generation), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
